dac_waveform_gen: RTL and testbench
===================================

# dac_waveform_gen

Sample-rate waveform source that sits directly upstream of the AD5626 DAC write stage. Produces a 12-bit sample at a fixed rate (DC, sawtooth, triangle or square, chosen by `mode`) and hands each one to the DAC writer through its `dac`/`set`/`busy` handshake. It counts samples dropped because the writer was still busy, so firmware can detect a `SAMPLE_DIV` that is too short.

## Interface
- `SAMPLE_DIV`, default 1000: clk cycles per sample period (100 kHz at 100 MHz); legal range 2..65535.
- `clk`  in  1  onboard 100 MHz clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  high runs the generator; low stops it after any in-flight write.
- `mode`  in  2  waveform select: 0 DC, 1 sawtooth, 2 triangle, 3 square; sampled only at a tick.
- `step`  in  12  phase increment per sample; sampled only at a tick.
- `level`  in  12  DC value, and the square-wave high value; sampled only at a tick.
- `busy`  in  1  from the DAC writer; high while a write is in progress.
- `dac`  out  12  sample word to the DAC writer; stable whenever `set` is high.
- `set`  out  1  write strobe to the DAC writer.
- `overrun_count`  out  8  number of dropped samples; saturates at 255.

## Operation
- Reset (async, `rst_n` low) sets: `dac`=0, `set`=0, `overrun_count`=0, phase=0, tick counter=0, state IDLE.
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 while `enable` is high, then wraps to 0.
  - A tick is the edge on which the counter wraps.
  - When `enable` is low, counter and phase are cleared to 0 synchronously.
- Phase accumulator: 12 bits. On every tick, phase <= phase + `step` mod 4096. This happens on dropped ticks too, so output frequency is preserved.
- Sample is computed from the phase value *before* the update:
  - DC: `level`.
  - Saw: phase.
  - Triangle: phase[11] ? ~{phase[10:0],0} : {phase[10:0],0}.
  - Square: phase[11] ? 0 : `level`.
- FSM states:
  - IDLE: `set`=0. Go to WAIT_TICK when `enable` is sampled high.
  - WAIT_TICK:
    - On tick: `dac` <= sample, `set` <= 1, go to ISSUE.
    - If `enable` is sampled low: go to IDLE.
  - ISSUE: hold `set`=1 and `dac` stable. When `busy` is sampled high: `set` <= 0, go to WAIT_DONE.
  - WAIT_DONE: when `busy` is sampled low, go to WAIT_TICK, or to IDLE if `enable` is low.
- Overrun: a tick while in ISSUE or WAIT_DONE drops that sample. `overrun_count` increments, saturating at 255. The transaction in flight is not disturbed.
- `enable` falling during ISSUE/WAIT_DONE: the transaction completes normally, then the FSM goes to IDLE. `dac` keeps its last value.
- Reset mid-transaction: `set` drops immediately (async). The downstream writer is allowed to finish its own cycle.
- `overrun_count` is cleared only by reset.

## Timing
- First tick lands on the SAMPLE_DIV-th rising edge after `enable` is first sampled high. Later ticks are every SAMPLE_DIV edges.
- `dac` and `set` are registered and change on the tick edge. The first sample after enable always uses phase 0.
- The writer latches on the first edge where `set`=1 and `busy`=0, and raises `busy` one cycle later. `set` is therefore high for about 2 cycles, and drops on the edge after `busy` is seen high.
- One full write = tick -> ISSUE -> WAIT_DONE -> WAIT_TICK. This takes the writer's busy time plus about 3 cycles.
- SAMPLE_DIV must exceed the writer's busy time plus 3. With the writer's default DELAY_FACTOR of 10, that is about 290 cycles. Shorter values produce overruns by design.

## Structure
- Package `dac_gen_pkg`:
  - Mode constants `MODE_DC`, `MODE_SAW`, `MODE_TRI`, `MODE_SQR`.
  - FSM state encoding `ST_IDLE`, `ST_WAIT_TICK`, `ST_ISSUE`, `ST_WAIT_DONE`.
  - Width constant `DAC_W`=12.
- One sub-module, `sample_tick`: the parameterised divider with synchronous clear. It outputs a 1-cycle `tick`.
- Phase, sample mux, FSM and overrun counter stay in the top module.

## Test plan
- Bench drives `busy` from a model of the writer: latch on `set`&&!`busy`, then hold `busy` high for N cycles.
- Reset and defaults:
  - Stimulus: assert `rst_n` low mid-ISSUE.
  - Required: `set`=0, `dac`=0 and `overrun_count`=0 immediately; first tick SAMPLE_DIV edges after `enable` is seen high.
- Sawtooth:
  - Stimulus: SAMPLE_DIV=300, `step`=0x400, N=270.
  - Required: `dac` sequence 0x000, 0x400, 0x800, 0xC00, 0x000; ticks exactly 300 cycles apart; `overrun_count` stays 0.
- Triangle and square:
  - Triangle with `step`=0x400 -> 0x000, 0x800, 0xFFF, 0x7FF.
  - Square with `level`=0xABC -> 0xABC, 0xABC, 0x000, 0x000.
- Handshake:
  - `set` rises on the tick edge and falls the edge after `busy` is seen high.
  - `dac` is unchanged from `set` rise until `busy` rises.
- Overrun:
  - Stimulus: SAMPLE_DIV=100, N=250.
  - Required: every second and third tick dropped; `overrun_count` increments by 2 per write and saturates at 255; phase still advances by `step` on each dropped tick.
- Disable mid-write:
  - Stimulus: drop `enable` during WAIT_DONE.
  - Required: write completes, FSM goes to IDLE, no further `set`; re-enable restarts from phase 0.

Source files
------------

// File: rtl/dac_gen_pkg.sv
// Shared constants, encodings and the waveform sample function for the
// DAC waveform generator.
package dac_gen_pkg;

  localparam int unsigned DAC_W = 12;
  localparam int unsigned OVR_W = 8;

  typedef enum logic [1:0] {
    MODE_DC  = 2'd0,
    MODE_SAW = 2'd1,
    MODE_TRI = 2'd2,
    MODE_SQR = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_ISSUE     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  // Map a phase to a sample; the triangle folds the upper half downward.
  function automatic logic [DAC_W-1:0] wave_sample(input mode_e mode,
                                                   input logic [DAC_W-1:0] phase,
                                                   input logic [DAC_W-1:0] level);
    logic [DAC_W-1:0] ramp;
    logic [DAC_W-1:0] smp;
    ramp = {phase[DAC_W-2:0], 1'b0};
    case (mode)
      MODE_DC:  smp = level;
      MODE_SAW: smp = phase;
      MODE_TRI: smp = phase[DAC_W-1] ? ~ramp : ramp;
      MODE_SQR: smp = phase[DAC_W-1] ? '0 : level;
      default:  smp = '0;
    endcase
    return smp;
  endfunction

endpackage

// File: rtl/dac_waveform_gen_sample_tick.sv
// Sample-period divider: counts 0..DIV-1 while enabled and flags the wrap
// cycle; disabling clears the count synchronously.
module sample_tick #(
  parameter int unsigned DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb tick_c = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!en || tick_c) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dac_waveform_gen.sv
// Fixed-rate waveform source feeding the DAC writer through a set/busy
// handshake, counting samples dropped while a write is still in flight.
module dac_waveform_gen
  import dac_gen_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [11:0]      step,
  input  logic [11:0]      level,
  input  logic             busy,
  output logic [11:0]      dac,
  output logic             set,
  output logic [7:0]       overrun_count
);

  state_e           state_q, state_d;
  logic [DAC_W-1:0] phase_q, phase_d;
  logic [DAC_W-1:0] dac_q, dac_d;
  logic             set_q, set_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;
  logic             tick_c;
  logic             drop_c;

  sample_tick #(.DIV(SAMPLE_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (enable),
    .tick_c (tick_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (enable) state_d = ST_WAIT_TICK;
      ST_WAIT_TICK: begin
        if (tick_c)       state_d = ST_ISSUE;
        else if (!enable) state_d = ST_IDLE;
      end
      ST_ISSUE:     if (busy) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!busy) state_d = enable ? ST_WAIT_TICK : ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Phase keeps advancing on dropped ticks so output frequency is preserved.
  always_comb begin
    phase_d = phase_q;
    dac_d   = dac_q;
    set_d   = set_q;
    ovr_d   = ovr_q;
    drop_c  = tick_c && ((state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE));

    if (!enable)     phase_d = '0;
    else if (tick_c) phase_d = phase_q + step;

    case (state_q)
      ST_IDLE:      set_d = 1'b0;
      ST_WAIT_TICK: begin
        if (tick_c) begin
          dac_d = wave_sample(mode_e'(mode), phase_q, level);
          set_d = 1'b1;
        end
      end
      ST_ISSUE:     if (busy) set_d = 1'b0;
      ST_WAIT_DONE: set_d = 1'b0;
      default:      set_d = 1'b0;
    endcase

    if (drop_c && (ovr_q != {OVR_W{1'b1}})) ovr_d = ovr_q + OVR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      dac_q   <= '0;
      set_q   <= 1'b0;
      ovr_q   <= '0;
    end else begin
      phase_q <= phase_d;
      dac_q   <= dac_d;
      set_q   <= set_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dac           = dac_q;
  assign set           = set_q;
  assign overrun_count = ovr_q;

endmodule

// File: tb/tb_dac_waveform_gen.sv
// Directed bench for dac_waveform_gen: one instance with a relaxed sample
// period, one with a short period against a slow writer to force overruns.
module tb_dac_waveform_gen;
  import dac_gen_pkg::*;

  localparam int DIV_A = 300;
  localparam int DIV_B = 100;
  localparam int N_A   = 270;
  localparam int N_B   = 250;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        enable_a = 1'b0, enable_b = 1'b0;
  logic [1:0]  mode_a = 2'd0, mode_b = 2'd0;
  logic [11:0] step_a = '0, step_b = '0;
  logic [11:0] level_a = '0, level_b = '0;
  logic        busy_a = 1'b0, busy_b = 1'b0;
  logic [11:0] dac_a, dac_b;
  logic        set_a, set_b;
  logic [7:0]  ovr_a, ovr_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int          ra_cyc[$];
  logic [11:0] ra_dac[$];
  int          rb_cyc[$];
  logic [11:0] rb_dac[$];
  logic [7:0]  rb_ovr[$];
  logic        set_a_p = 1'b0, set_b_p = 1'b0;
  int          wcnt_a = 0, wcnt_b = 0;

  dac_waveform_gen #(.SAMPLE_DIV(DIV_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable_a), .mode(mode_a), .step(step_a),
    .level(level_a), .busy(busy_a), .dac(dac_a), .set(set_a), .overrun_count(ovr_a)
  );

  dac_waveform_gen #(.SAMPLE_DIV(DIV_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .mode(mode_b), .step(step_b),
    .level(level_b), .busy(busy_b), .dac(dac_b), .set(set_b), .overrun_count(ovr_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Writer models: latch on set && !busy, then hold busy for N cycles.
  always @(posedge clk) begin
    if (busy_a) begin
      if (wcnt_a == 0) busy_a <= 1'b0;
      else             wcnt_a <= wcnt_a - 1;
    end else if (set_a) begin
      busy_a <= 1'b1;
      wcnt_a <= N_A - 1;
    end
    if (busy_b) begin
      if (wcnt_b == 0) busy_b <= 1'b0;
      else             wcnt_b <= wcnt_b - 1;
    end else if (set_b) begin
      busy_b <= 1'b1;
      wcnt_b <= N_B - 1;
    end
  end

  // Record each set rise with the edge number and the presented word.
  always @(negedge clk) begin
    if (set_a && !set_a_p) begin
      ra_cyc.push_back(cyc);
      ra_dac.push_back(dac_a);
    end
    if (set_b && !set_b_p) begin
      rb_cyc.push_back(cyc);
      rb_dac.push_back(dac_b);
      rb_ovr.push_back(ovr_b);
    end
    set_a_p = set_a;
    set_b_p = set_b;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_rises_a(input int n, input int limit, output bit ok);
    int k = 0;
    while (ra_cyc.size() < n && k < limit) begin
      tick_n(1);
      k++;
    end
    ok = (ra_cyc.size() >= n);
  endtask

  task automatic wait_rises_b(input int n, input int limit, output bit ok);
    int k = 0;
    while (rb_cyc.size() < n && k < limit) begin
      tick_n(1);
      k++;
    end
    ok = (rb_cyc.size() >= n);
  endtask

  task automatic quiesce_a();
    int k = 0;
    enable_a = 1'b0;
    while ((set_a || busy_a) && k < 1000) begin
      tick_n(1);
      k++;
    end
    tick_n(3);
  endtask

  task automatic run_a(input logic [1:0] m, input logic [11:0] st, input logic [11:0] lv,
                       input int n, output bit ok, output int e);
    ra_cyc.delete();
    ra_dac.delete();
    mode_a   = m;
    step_a   = st;
    level_a  = lv;
    enable_a = 1'b1;
    e = cyc + 1;
    wait_rises_a(n, n * DIV_A + DIV_A, ok);
    quiesce_a();
  endtask

  task automatic test_reset();
    bit ok;
    int e;
    tick_n(3);
    rst_n = 1'b1;
    tick_n(1);
    n_cmp++; if (set_a !== 1'b0) begin n_bad++; $display("FAIL rst_set: got %b want 0", set_a); end
    n_cmp++; if (dac_a !== 12'h000) begin n_bad++; $display("FAIL rst_dac: got %h want 000", dac_a); end
    n_cmp++; if (ovr_b !== 8'd0) begin n_bad++; $display("FAIL rst_ovr: got %0d want 0", ovr_b); end
    ra_cyc.delete();
    ra_dac.delete();
    mode_a   = MODE_DC;
    level_a  = 12'h5A5;
    enable_a = 1'b1;
    e = cyc + 1;
    wait_rises_a(1, 400, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL first_tick_timeout: got no set want set"); end
    if (ok) begin
      n_cmp++; if (ra_cyc[0] !== e + DIV_A - 1) begin n_bad++; $display("FAIL first_tick_edge: got %0d want %0d", ra_cyc[0], e + DIV_A - 1); end
      n_cmp++; if (ra_dac[0] !== 12'h5A5) begin n_bad++; $display("FAIL dc_dac: got %h want 5a5", ra_dac[0]); end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (set_a !== 1'b0) begin n_bad++; $display("FAIL midissue_rst_set: got %b want 0", set_a); end
    n_cmp++; if (dac_a !== 12'h000) begin n_bad++; $display("FAIL midissue_rst_dac: got %h want 000", dac_a); end
    enable_a = 1'b0;
    tick_n(2);
    rst_n = 1'b1;
    tick_n(2);
  endtask

  task automatic test_sawtooth();
    bit ok;
    int e;
    logic [11:0] want [5] = '{12'h000, 12'h400, 12'h800, 12'hC00, 12'h000};
    run_a(MODE_SAW, 12'h400, 12'h000, 5, ok, e);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL saw_timeout: got %0d writes want 5", ra_cyc.size()); end
    if (ok) begin
      n_cmp++; if (ra_cyc[0] !== e + DIV_A - 1) begin n_bad++; $display("FAIL saw_first_edge: got %0d want %0d", ra_cyc[0], e + DIV_A - 1); end
      for (int i = 0; i < 5; i++) begin
        n_cmp++; if (ra_dac[i] !== want[i]) begin n_bad++; $display("FAIL saw_dac[%0d]: got %h want %h", i, ra_dac[i], want[i]); end
        if (i > 0) begin
          n_cmp++; if (ra_cyc[i] - ra_cyc[i-1] !== DIV_A) begin n_bad++; $display("FAIL saw_period[%0d]: got %0d want %0d", i, ra_cyc[i] - ra_cyc[i-1], DIV_A); end
        end
      end
    end
    n_cmp++; if (ovr_a !== 8'd0) begin n_bad++; $display("FAIL saw_ovr: got %0d want 0", ovr_a); end
  endtask

  task automatic test_triangle();
    bit ok;
    int e;
    logic [11:0] want [4] = '{12'h000, 12'h800, 12'hFFF, 12'h7FF};
    run_a(MODE_TRI, 12'h400, 12'h000, 4, ok, e);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL tri_timeout: got %0d writes want 4", ra_cyc.size()); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (ra_dac[i] !== want[i]) begin n_bad++; $display("FAIL tri_dac[%0d]: got %h want %h", i, ra_dac[i], want[i]); end
      end
    end
  endtask

  task automatic test_square();
    bit ok;
    int e;
    logic [11:0] want [4] = '{12'hABC, 12'hABC, 12'h000, 12'h000};
    run_a(MODE_SQR, 12'h400, 12'hABC, 4, ok, e);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL sqr_timeout: got %0d writes want 4", ra_cyc.size()); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (ra_dac[i] !== want[i]) begin n_bad++; $display("FAIL sqr_dac[%0d]: got %h want %h", i, ra_dac[i], want[i]); end
      end
    end
  endtask

  task automatic test_handshake();
    bit ok;
    ra_cyc.delete();
    ra_dac.delete();
    mode_a   = MODE_SAW;
    step_a   = 12'h123;
    enable_a = 1'b1;
    wait_rises_a(2, 3 * DIV_A, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL hs_timeout: got %0d writes want 2", ra_cyc.size()); end
    if (ok) begin
      n_cmp++; if ({set_a, busy_a, dac_a} !== {1'b1, 1'b0, 12'h123}) begin n_bad++; $display("FAIL hs_tick: got set=%b busy=%b dac=%h want 1 0 123", set_a, busy_a, dac_a); end
      tick_n(1);
      n_cmp++; if ({set_a, busy_a, dac_a} !== {1'b1, 1'b1, 12'h123}) begin n_bad++; $display("FAIL hs_latch: got set=%b busy=%b dac=%h want 1 1 123", set_a, busy_a, dac_a); end
      tick_n(1);
      n_cmp++; if ({set_a, dac_a} !== {1'b0, 12'h123}) begin n_bad++; $display("FAIL hs_drop: got set=%b dac=%h want 0 123", set_a, dac_a); end
    end
    quiesce_a();
  endtask

  task automatic test_disable();
    bit ok;
    int e;
    int k = 0;
    ra_cyc.delete();
    ra_dac.delete();
    mode_a   = MODE_SAW;
    step_a   = 12'h400;
    enable_a = 1'b1;
    wait_rises_a(2, 3 * DIV_A, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL dis_timeout: got %0d writes want 2", ra_cyc.size()); end
    while (!busy_a && k < 20) begin tick_n(1); k++; end
    tick_n(5);
    enable_a = 1'b0;
    tick_n(700);
    n_cmp++; if (ra_cyc.size() !== 2) begin n_bad++; $display("FAIL dis_no_set: got %0d writes want 2", ra_cyc.size()); end
    n_cmp++; if ({set_a, busy_a, dac_a} !== {1'b0, 1'b0, 12'h400}) begin n_bad++; $display("FAIL dis_idle: got set=%b busy=%b dac=%h want 0 0 400", set_a, busy_a, dac_a); end
    ra_cyc.delete();
    ra_dac.delete();
    enable_a = 1'b1;
    e = cyc + 1;
    wait_rises_a(1, 2 * DIV_A, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL reen_timeout: got no set want set"); end
    if (ok) begin
      n_cmp++; if (ra_dac[0] !== 12'h000) begin n_bad++; $display("FAIL reen_phase: got %h want 000", ra_dac[0]); end
      n_cmp++; if (ra_cyc[0] !== e + DIV_A - 1) begin n_bad++; $display("FAIL reen_edge: got %0d want %0d", ra_cyc[0], e + DIV_A - 1); end
    end
    quiesce_a();
  endtask

  task automatic test_overrun();
    bit ok;
    int e;
    rb_cyc.delete();
    rb_dac.delete();
    rb_ovr.delete();
    mode_b   = MODE_SAW;
    step_b   = 12'h010;
    enable_b = 1'b1;
    e = cyc + 1;
    wait_rises_b(4, 4 * 3 * DIV_B + 200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovr_timeout: got %0d writes want 4", rb_cyc.size()); end
    if (ok) begin
      n_cmp++; if (rb_cyc[0] !== e + DIV_B - 1) begin n_bad++; $display("FAIL ovr_first_edge: got %0d want %0d", rb_cyc[0], e + DIV_B - 1); end
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (rb_dac[i] !== 12'(i * 48)) begin n_bad++; $display("FAIL ovr_dac[%0d]: got %h want %h", i, rb_dac[i], 12'(i * 48)); end
        n_cmp++; if (rb_ovr[i] !== 8'(2 * i)) begin n_bad++; $display("FAIL ovr_count[%0d]: got %0d want %0d", i, rb_ovr[i], 2 * i); end
        if (i > 0) begin
          n_cmp++; if (rb_cyc[i] - rb_cyc[i-1] !== 3 * DIV_B) begin n_bad++; $display("FAIL ovr_period[%0d]: got %0d want %0d", i, rb_cyc[i] - rb_cyc[i-1], 3 * DIV_B); end
        end
      end
    end
    tick_n(130 * 3 * DIV_B);
    n_cmp++; if (ovr_b !== 8'd255) begin n_bad++; $display("FAIL ovr_saturate: got %0d want 255", ovr_b); end
  endtask

  task automatic test_reset_mid_issue();
    bit ok;
    rb_cyc.delete();
    rb_dac.delete();
    rb_ovr.delete();
    wait_rises_b(1, 4 * DIV_B, ok);
    n_cmp++; if (!ok || set_b !== 1'b1) begin n_bad++; $display("FAIL rb_issue: got set=%b want 1", set_b); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({set_b, dac_b, ovr_b} !== {1'b0, 12'h000, 8'd0}) begin n_bad++; $display("FAIL rb_async: got set=%b dac=%h ovr=%0d want 0 000 0", set_b, dac_b, ovr_b); end
    enable_b = 1'b0;
    tick_n(2);
    rst_n = 1'b1;
    tick_n(2);
  endtask

  initial begin
    test_reset();
    test_sawtooth();
    test_triangle();
    test_square();
    test_handshake();
    test_disable();
    test_overrun();
    test_reset_mid_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
